// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared rv32i types and the memory-port arbiter state encoding
package rv32i_types;

  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] cache_line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - 32-bit saturating event counter with clear priority over increment
module sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin share of one pmem line port between I-cache and D-cache misses
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [31:0]           i_stall_count,
  output logic [31:0]           d_stall_count,
  input  logic                  i_stall_reset,
  input  logic                  d_stall_reset
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic       d_req;

  assign d_req = d_read | d_write;

  // Grant decision is taken only from IDLE, so every completion forces one idle cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_read && d_req) begin
          state_d = last_grant_q ? SERVE_I : SERVE_D;
        end else if (i_read) begin
          state_d = SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (state_q)
      SERVE_I: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        i_resp      = mem_resp;
      end
      SERVE_D: begin
        mem_address = d_address;
        d_resp      = mem_resp;
        if (d_write) begin
          mem_write = 1'b1;
          mem_wdata = d_wdata;
        end else begin
          mem_read = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  sat_counter u_i_stall (
    .clk     (clk),
    .reset   (reset),
    .clear_i (i_stall_reset),
    .inc_i   (i_read && (state_q != SERVE_I)),
    .count_o (i_stall_count)
  );

  sat_counter u_d_stall (
    .clk     (clk),
    .reset   (reset),
    .clear_i (d_stall_reset),
    .inc_i   (d_req && (state_q != SERVE_D)),
    .count_o (d_stall_count)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam logic [LW-1:0] LINE_AA = {32{8'hAA}};
  localparam logic [LW-1:0] LINE_WB = {8{32'h1234_5678}};
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [31:0]   i_stall_count, d_stall_count;
  logic          i_stall_reset, d_stall_reset;

  int checks = 0;
  int failures = 0;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .i_stall_count(i_stall_count), .d_stall_count(d_stall_count),
    .i_stall_reset(i_stall_reset), .d_stall_reset(d_stall_reset)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    i_stall_reset = 0; d_stall_reset = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mem_resp = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read: got %0b want 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write: got %0b want 0", mem_write); end
    checks++; if (mem_address !== '0) begin failures++; $display("FAIL reset_mem_address: got %0h want 0", mem_address); end
    checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
    checks++; if ({i_resp, d_resp} !== 2'b00) begin failures++; $display("FAIL reset_resp: got %b want 00", {i_resp, d_resp}); end
    checks++; if (i_stall_count !== 32'd0) begin failures++; $display("FAIL reset_i_stall: got %0h want 0", i_stall_count); end
    checks++; if (d_stall_count !== 32'd0) begin failures++; $display("FAIL reset_d_stall: got %0h want 0", d_stall_count); end
    mem_resp = 1'b0;
    next_cycle();
  endtask

  task automatic test_i_only();
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0060; mem_rdata = LINE_AA;
    #1;
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL i_only_arb_cycle: mem_read=%0b want 0", mem_read); end
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      mem_resp = (c == 3);
      #1;
      checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL i_only_strobe c%0d: rd=%0b wr=%0b want 1/0", c, mem_read, mem_write); end
      checks++; if (mem_address !== 32'h60) begin failures++; $display("FAIL i_only_addr c%0d: got %0h want 60", c, mem_address); end
      checks++; if (i_resp !== (c == 3)) begin failures++; $display("FAIL i_only_resp c%0d: got %0b want %0b", c, i_resp, (c == 3)); end
      checks++; if (d_resp !== 1'b0) begin failures++; $display("FAIL i_only_d_resp c%0d: got %0b want 0", c, d_resp); end
      if (c == 3) begin
        checks++; if (i_rdata !== LINE_AA) begin failures++; $display("FAIL i_only_rdata: got %0h want %0h", i_rdata, LINE_AA); end
      end
      next_cycle();
    end
    mem_resp = 1'b0; i_read = 1'b0;
    #1;
    checks++; if (i_resp !== 1'b0 || mem_read !== 1'b0) begin failures++; $display("FAIL i_only_after: resp=%0b rd=%0b want 0/0", i_resp, mem_read); end
    checks++; if (i_stall_count !== 32'd1) begin failures++; $display("FAIL i_only_stall: got %0d want 1", i_stall_count); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_read = 1'b1; d_read = 1'b1; i_address = 32'h100; d_address = 32'h200; mem_rdata = rand_line();
    #1;
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL sim_arb_cycle: mem_read=%0b want 0", mem_read); end
    next_cycle();
    for (int c = 1; c <= 2; c++) begin
      mem_resp = (c == 2);
      #1;
      checks++; if (mem_read !== 1'b1 || mem_address !== 32'h100) begin failures++; $display("FAIL sim_i_first c%0d: rd=%0b addr=%0h want 1/100", c, mem_read, mem_address); end
      checks++; if (i_resp !== (c == 2) || d_resp !== 1'b0) begin failures++; $display("FAIL sim_i_resp c%0d: i=%0b d=%0b", c, i_resp, d_resp); end
      next_cycle();
    end
    i_read = 1'b0; mem_resp = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL sim_idle_gap: rd=%0b d_resp=%0b want 0/0", mem_read, d_resp); end
    next_cycle();
    #1;
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h200) begin failures++; $display("FAIL sim_d_grant: rd=%0b addr=%0h want 1/200", mem_read, mem_address); end
    checks++; if (d_stall_count !== 32'd4) begin failures++; $display("FAIL sim_d_stall: got %0d want 4", d_stall_count); end
    checks++; if (i_stall_count !== 32'd1) begin failures++; $display("FAIL sim_i_stall: got %0d want 1", i_stall_count); end
    mem_resp = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin failures++; $display("FAIL sim_d_resp: d=%0b i=%0b want 1/0", d_resp, i_resp); end
    next_cycle();
    d_read = 1'b0; mem_resp = 1'b0;
    next_cycle();
  endtask

  task automatic test_alternation();
    int grants = 0;
    int idle_run = 0;
    int served = 0;
    int len = 1;
    int cycles = 0;
    bit active = 0;
    logic [AW-1:0] exp_addr;
    do_reset();
    i_read = 1'b1; d_read = 1'b1; i_address = 32'hA0; d_address = 32'hD0;
    while (grants < 4 && cycles < 100) begin
      mem_resp = 1'b0;
      #1;
      if (mem_read || mem_write) begin
        if (!active) begin
          exp_addr = (grants % 2 == 0) ? 32'hA0 : 32'hD0;
          checks++; if (mem_address !== exp_addr) begin failures++; $display("FAIL alt_order g%0d: addr=%0h want %0h", grants, mem_address, exp_addr); end
          checks++; if (idle_run != 1) begin failures++; $display("FAIL alt_gap g%0d: idle cycles=%0d want 1", grants, idle_run); end
          active = 1; served = 0; idle_run = 0; len = $urandom_range(1, 3);
        end
        served++;
        if (served == len) begin
          mem_resp = 1'b1;
          #1;
          checks++; if (((grants % 2 == 0) ? i_resp : d_resp) !== 1'b1) begin failures++; $display("FAIL alt_resp g%0d: i=%0b d=%0b", grants, i_resp, d_resp); end
          active = 0;
          grants++;
        end
      end else begin
        idle_run++;
      end
      next_cycle();
      cycles++;
    end
    i_read = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
    checks++; if (grants != 4) begin failures++; $display("FAIL alt_done: grants=%0d want 4", grants); end
    next_cycle();
  endtask

  task automatic test_writeback();
    do_reset();
    d_write = 1'b1; d_read = 1'b1; d_address = 32'h0000_1000; d_wdata = LINE_WB;
    #1;
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL wb_arb_cycle: mem_write=%0b want 0", mem_write); end
    next_cycle();
    #1;
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL wb_strobe: wr=%0b rd=%0b want 1/0", mem_write, mem_read); end
    checks++; if (mem_wdata !== LINE_WB) begin failures++; $display("FAIL wb_wdata: got %0h want %0h", mem_wdata, LINE_WB); end
    checks++; if (mem_address !== 32'h1000) begin failures++; $display("FAIL wb_addr: got %0h want 1000", mem_address); end
    mem_resp = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin failures++; $display("FAIL wb_resp: d=%0b i=%0b want 1/0", d_resp, i_resp); end
    next_cycle();
    d_write = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
    #1;
    checks++; if (d_resp !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL wb_single_pulse: d=%0b wr=%0b want 0/0", d_resp, mem_write); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_write = 1'b1; d_address = 32'h2000; d_wdata = rand_line();
    next_cycle();
    #1;
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rmid_pre: mem_write=%0b want 1", mem_write); end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; d_write = 1'b0; mem_resp = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin failures++; $display("FAIL rmid_strobes c%0d: wr=%0b rd=%0b want 0/0", c, mem_write, mem_read); end
      checks++; if (d_resp !== 1'b0 || i_resp !== 1'b0) begin failures++; $display("FAIL rmid_resp c%0d: d=%0b i=%0b want 0/0", c, d_resp, i_resp); end
      checks++; if (i_stall_count !== 32'd0 || d_stall_count !== 32'd0) begin failures++; $display("FAIL rmid_counters c%0d: i=%0d d=%0d want 0/0", c, i_stall_count, d_stall_count); end
      next_cycle();
    end
    mem_resp = 1'b0;
    next_cycle();
  endtask

  task automatic test_saturation();
    logic [31:0] exp_seq [5];
    exp_seq[0] = 32'hFFFF_FFFE; exp_seq[1] = 32'hFFFF_FFFF; exp_seq[2] = 32'hFFFF_FFFF;
    exp_seq[3] = 32'h0;         exp_seq[4] = 32'h1;
    do_reset();
    d_read = 1'b1; d_address = 32'h40;
    next_cycle();
    force dut.u_i_stall.count_q = 32'hFFFF_FFFD;
    #1;
    release dut.u_i_stall.count_q;
    i_read = 1'b1; i_address = 32'h80;
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (i_stall_count !== exp_seq[c]) begin failures++; $display("FAIL sat_seq c%0d: got %0h want %0h", c, i_stall_count, exp_seq[c]); end
      checks++; if (mem_read !== 1'b1 || mem_address !== 32'h40) begin failures++; $display("FAIL sat_grant_held c%0d: rd=%0b addr=%0h", c, mem_read, mem_address); end
      i_stall_reset = (c == 2);
      next_cycle();
    end
    #1;
    checks++; if (d_stall_count !== 32'd1) begin failures++; $display("FAIL sat_d_stall: got %0d want 1", d_stall_count); end
    mem_resp = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin failures++; $display("FAIL sat_d_resp: d=%0b i=%0b want 1/0", d_resp, i_resp); end
    next_cycle();
    d_read = 1'b0; i_read = 1'b0; mem_resp = 1'b0;
    next_cycle();
  endtask

  // Reference model: owner of the port (0 none, 1 I, 2 D) and who went last.
  task automatic test_random();
    int owner = 0;
    int went_last = 2;
    int delay = 0;
    longint ic = 0;
    longint dc = 0;
    bit ip = 0;
    bit dp = 0;
    int dkind = 0;
    bit dreq, exp_rd, exp_wr, exp_ir, exp_dr;
    logic [AW-1:0] exp_addr;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      i_read  = ip;
      d_read  = dp && (dkind != 1);
      d_write = dp && (dkind != 0);
      mem_resp = (owner != 0) ? (delay == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = rand_line();
      d_wdata = rand_line();
      i_stall_reset = ($urandom_range(0, 15) == 0);
      d_stall_reset = ($urandom_range(0, 15) == 0);
      #1;
      dreq = d_read || d_write;
      exp_rd = (owner == 1) || (owner == 2 && !d_write);
      exp_wr = (owner == 2) && d_write;
      exp_addr = (owner == 1) ? i_address : (owner == 2) ? d_address : '0;
      exp_ir = (owner == 1) && mem_resp;
      exp_dr = (owner == 2) && mem_resp;
      checks++; if (mem_read !== exp_rd || mem_write !== exp_wr) begin failures++; $display("FAIL rnd_strobe n%0d: rd=%0b wr=%0b want %0b/%0b", n, mem_read, mem_write, exp_rd, exp_wr); end
      checks++; if (mem_address !== exp_addr) begin failures++; $display("FAIL rnd_addr n%0d: got %0h want %0h", n, mem_address, exp_addr); end
      checks++; if (i_resp !== exp_ir || d_resp !== exp_dr) begin failures++; $display("FAIL rnd_resp n%0d: i=%0b d=%0b want %0b/%0b", n, i_resp, d_resp, exp_ir, exp_dr); end
      checks++; if (i_rdata !== mem_rdata || d_rdata !== mem_rdata) begin failures++; $display("FAIL rnd_rdata n%0d: i=%0h d=%0h", n, i_rdata, d_rdata); end
      if (exp_wr) begin
        checks++; if (mem_wdata !== d_wdata) begin failures++; $display("FAIL rnd_wdata n%0d: got %0h want %0h", n, mem_wdata, d_wdata); end
      end
      checks++; if (i_stall_count !== ic[31:0]) begin failures++; $display("FAIL rnd_i_stall n%0d: got %0d want %0d", n, i_stall_count, ic); end
      checks++; if (d_stall_count !== dc[31:0]) begin failures++; $display("FAIL rnd_d_stall n%0d: got %0d want %0d", n, d_stall_count, dc); end
      if (i_stall_reset) ic = 0; else if (i_read && owner != 1 && ic < CMAX) ic = ic + 1;
      if (d_stall_reset) dc = 0; else if (dreq && owner != 2 && dc < CMAX) dc = dc + 1;
      if (owner == 0) begin
        if (i_read && dreq) owner = (went_last == 1) ? 2 : 1;
        else if (i_read) owner = 1;
        else if (dreq) owner = 2;
        delay = $urandom_range(0, 3);
      end else if (mem_resp) begin
        went_last = owner;
        owner = 0;
      end else begin
        delay--;
      end
      if (exp_ir) ip = 0;
      else if (ip && owner == 1 && $urandom_range(0, 19) == 0) ip = 0;
      else if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; i_address = $urandom & ~32'h1F; end
      if (exp_dr) dp = 0;
      else if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; dkind = $urandom_range(0, 2); d_address = $urandom & ~32'h1F;
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_simultaneous();
    test_alternation();
    test_writeback();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
